// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state, condition, command, ALU and shifter encodings plus the control-word layout.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EXEC_R  = 4'd2,
        EXEC_I  = 4'd3,
        ALU_WB  = 4'd4,
        MEM_ADR = 4'd5,
        MEM_RD  = 4'd6,
        MEM_WB  = 4'd7,
        MEM_WR  = 4'd8,
        BRANCH  = 4'd9,
        STALL   = 4'd10
    } state_t;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [2:0] SHIFT_NONE = 3'b111;

    typedef struct packed {
        logic       a3_src;
        logic       adr_src;
        logic       flag_update;
        logic       ir_write;
        logic       mem_write;
        logic       pc_write;
        logic       reg_write;
        logic       wd3_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] reg_src;
        logic [2:0] alu_op;
        logic [2:0] shift_type;
    } ctrl_t;

    localparam ctrl_t CTRL_DEF = ctrl_t'({19'd0, SHIFT_NONE});

    function automatic logic cmd_valid(input logic [3:0] cmd);
        return cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_MOV, CMD_CMP};
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [3:0] cmd);
        return (cmd == CMD_SUB || cmd == CMD_CMP) ? ALU_SUB :
               (cmd == CMD_AND) ? ALU_AND :
               (cmd == CMD_ORR) ? ALU_ORR : ALU_ADD;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: IR/flags from the datapath and the control word driven back to it.
interface multicycle_controller_if #(parameter int INSTR_W = 32);

    logic [INSTR_W-1:0] INSTRUCTION;
    logic [3:0]         FLAGS;
    logic               A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src;
    logic [1:0]         ALUSrcA, ALUSrcB, ResultSrc, RegSrc;
    logic [2:0]         ALUop, ShiftType;

    modport master (
        input  INSTRUCTION, FLAGS,
        output A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
        output ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType
    );

    modport slave (
        output INSTRUCTION, FLAGS,
        input  A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
        input  ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType
    );

endinterface

// File: rtl/mc_cond_check.sv
// mc_cond_check: evaluates the instruction condition field against {N,Z,C,V}.
module mc_cond_check
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, v;
    logic unused_c;

    assign {n, z, unused_c, v} = flags;

    always_comb
        pass = (cond == COND_AL) ||
               (cond == COND_EQ && z) ||
               (cond == COND_NE && !z) ||
               (cond == COND_GE && n == v) ||
               (cond == COND_LT && n != v);

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle FSM producing datapath control; optional single-step mode via MC_CTRL_STEP_EN.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    multicycle_controller_if.master bus,
    input  logic                 step_req,
    output logic                 step_ack,
    output logic [CNT_W-1:0]     retired,
    output logic [3:0]           state_out
);

`ifdef MC_CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    state_t             state, state_nx;
    ctrl_t              c;
    logic [INSTR_W-1:0] instr_full;
    logic [31:0]        ir;
    logic [3:0]         cmd;
    logic [1:0]         op;
    logic               imm_b, pass, is_cmp, is_mov, retire, unused_ir;

    assign instr_full = bus.INSTRUCTION;
    assign ir         = instr_full[31:0];
    assign unused_ir  = ^instr_full;
    assign op         = ir[27:26];
    assign imm_b      = ir[25];
    assign cmd        = ir[24:21];
    assign is_cmp     = cmd == CMD_CMP;
    assign is_mov     = cmd == CMD_MOV;

    mc_cond_check u_cond (
        .cond  (ir[31:28]),
        .flags (bus.FLAGS),
        .pass  (pass)
    );

    always_comb begin
        c        = CTRL_DEF;
        state_nx = state;
        retire   = 1'b0;
        case (state)
            FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_b  = 2'b11;
                c.result_src = 2'b10;
                c.reg_src    = 2'b10;
                state_nx     = DECODE;
            end
            DECODE: begin
                retire   = !pass || op == 2'b11 || (op == 2'b00 && !cmd_valid(cmd));
                state_nx = op == 2'b00 ? (imm_b ? EXEC_I : EXEC_R) :
                           op == 2'b01 ? MEM_ADR : BRANCH;
            end
            EXEC_I, EXEC_R: begin
                c.alu_src_a   = is_mov ? 2'b10 : 2'b00;
                c.alu_src_b   = state == EXEC_I ? 2'b01 : 2'b00;
                c.shift_type  = state == EXEC_I ? SHIFT_NONE : ir[6:4];
                c.alu_op      = alu_op_of(cmd);
                c.flag_update = ir[20] || is_cmp;
                retire        = is_cmp;
                state_nx      = ALU_WB;
            end
            ALU_WB: begin
                c.reg_write = 1'b1;
                c.alu_src_a = 2'b01;
                retire      = 1'b1;
            end
            MEM_ADR: begin
                c.alu_src_b = 2'b01;
                state_nx    = cmd[0] ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                c.adr_src = 1'b1;
                state_nx  = MEM_WB;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.result_src = 2'b01;
                retire       = 1'b1;
            end
            MEM_WR: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
                retire      = 1'b1;
            end
            BRANCH: begin
                c.pc_write  = 1'b1;
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.a3_src    = imm_b;
                retire      = 1'b1;
            end
            STALL:   state_nx = (STEP_EN && !step_req) ? STALL : FETCH;
            default: state_nx = FETCH;
        endcase
        // a held step_req chains straight into the next fetch without parking in STALL
        if (retire)
            state_nx = (STEP_EN && !step_req) ? STALL : FETCH;
    end

    assign {bus.A3Src, bus.AdrSrc, bus.FlagUpdate, bus.IRWrite, bus.MemWrite, bus.PCWrite,
            bus.RegWrite, bus.WD3Src, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.RegSrc,
            bus.ALUop, bus.ShiftType} = reset ? CTRL_DEF : c;

    assign step_ack  = STEP_EN && retire && !reset;
    assign state_out = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            state <= state_nx;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter INSTR_W, default 32, instruction width; the field positions below are fixed at the top 32 bits' layout, and widths >32 zero-extend unused MSBs.
REQ-002 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 INSTRUCTION  input  INSTR_W  current IR contents from datapath.
REQ-006 FLAGS  input  4  {N,Z,C,V} from datapath.
REQ-007 step_req  input  1  single-step request (debug mode only).
REQ-008 A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src  output  1 each  datapath control strobes.
REQ-009 ALUSrcA, ALUSrcB, ResultSrc, RegSrc  output  2 each  datapath mux selects.
REQ-010 ALUop, ShiftType  output  3 each  ALU operation, shifter type.
REQ-011 step_ack  output  1  one-cycle pulse when a stepped instruction retires.
REQ-012 retired  output  CNT_W  count of retired instructions.
REQ-013 state_out  output  4  current FSM state encoding.

Function
REQ-014 Fields: cond[31:28], op[27:26], I[25], cmd[24:21], S[20], Rn[19:16], Rd[15:12], imm/Rm[11:0].
REQ-015 States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, STALL; encoded 0..10 on state_out.
REQ-016 Default control word (any state not listed): all strobes 0, all 2-bit selects 00, ALUop 000, ShiftType 111.
REQ-017 FETCH: IRWrite=1, PCWrite=1, ALUSrcB=11, ResultSrc=10, RegSrc=10; next DECODE.
REQ-018 DECODE: default word; cond false -> FETCH (instruction counted retired, no register/memory/flag writes); op=00,I=1 -> EXEC_I; op=00,I=0 -> EXEC_R; op=01 -> MEM_ADR; op=10 -> BRANCH; op=11 -> FETCH (NOP).
REQ-019 Conditions: 1110 always; 0000 EQ (Z=1); 0001 NE (Z=0); 1010 GE (N==V); 1011 LT (N!=V); all other codes false.
REQ-020 ALUop from cmd: 0100 ADD->000; 0010 SUB->001; 0000 AND->010; 1100 ORR->011; 1101 MOV->000 with ALUSrcA=10; 1010 CMP->001 with RegWrite suppressed; other cmd -> NOP, return to FETCH.
REQ-021 EXEC_I: ALUSrcB=01, ALUSrcA per REQ-020 (00 if not MOV), FlagUpdate=S (forced 1 for CMP); next ALU_WB, or FETCH for CMP.
REQ-022 EXEC_R: ALUSrcB=00, ShiftType=imm[6:4], same ALUop/flag rules; next ALU_WB, or FETCH for CMP.
REQ-023 ALU_WB: RegWrite=1, ALUSrcA=01, ResultSrc=00; next FETCH.
REQ-024 MEM_ADR: ALUSrcB=01, ALUop=000; cmd[0]=1 (load) -> MEM_RD, else MEM_WR.
REQ-025 MEM_RD: AdrSrc=1, ResultSrc=00 -> MEM_WB; MEM_WB: RegWrite=1, ResultSrc=01 -> FETCH; MEM_WR: AdrSrc=1, MemWrite=1 -> FETCH.
REQ-026 BRANCH: PCWrite=1, ALUSrcA=10, ALUSrcB=01, ResultSrc=00, A3Src=1 when I=1 (link); next FETCH.
REQ-027 Control outputs are a combinational function of state and INSTRUCTION; zero-cycle latency from state entry.
REQ-028 retired increments by 1 on the cycle leaving the instruction's final state into FETCH; wraps from 2^CNT_W-1 to 0.
REQ-029 Latency: data-processing 4 cycles, CMP/branch 3, load 5, store 4, condition-false/NOP 2.

Reset
REQ-030 reset asserted in any state, including mid-instruction, forces FETCH on next edge; retired=0, step_ack=0; no partial write completes after reset edge.
REQ-031 During reset cycle outputs show the FETCH-independent default word (REQ-016).

Configuration
REQ-032 Macro MC_CTRL_STEP_EN compiled in: FSM enters STALL instead of FETCH after each retire; STALL holds default word until step_req=1, then FETCH; step_ack pulses on retire cycle; step_req held high runs continuously with no STALL dwell.
REQ-033 Without MC_CTRL_STEP_EN: STALL unreachable, step_req ignored, step_ack tied 0.

Structure
REQ-034 Shared package mc_ctrl_pkg: state encodings, cond codes, cmd codes, ALUop and ShiftType constants.
REQ-035 One sub-module mc_cond_check: combinational cond/FLAGS evaluator.

Verification
REQ-036 reset for 1 cycle, then MOV R0,#13 (0xE3A0000D) -> FETCH,DECODE,EXEC_I(ALUSrcA=10,ALUSrcB=01),ALU_WB(RegWrite=1); retired=1.
REQ-037 ADDEQ with FLAGS=0000 -> FETCH,DECODE,FETCH; no RegWrite pulse; retired increments.
REQ-038 LDR (op=01,cmd[0]=1) -> 5-cycle sequence with MEM_WB ResultSrc=01; STR -> MemWrite=1 exactly one cycle.
REQ-039 reset asserted during ALU_WB -> next state FETCH, RegWrite=0 after edge, retired=0.
REQ-040 CNT_W=2, five retires -> retired sequence 1,2,3,0,1.
REQ-041 With MC_CTRL_STEP_EN, step_req=0 -> FSM holds STALL 10 cycles; step_req=1 one cycle -> one instruction runs, step_ack pulses once.
